// File: rtl/alu_chk_pkg.sv
// Shared types and the golden add/subtract reference for the ALU response checker.
package alu_chk_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam int GOLD_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {cout, s} in bits [w:0]; only the low w operand bits are inverted for subtract.
    function automatic logic [GOLD_W:0] golden(input logic [GOLD_W-1:0] a,
                                               input logic [GOLD_W-1:0] b,
                                               input logic              op,
                                               input int unsigned       w);
        logic [GOLD_W:0] one;
        logic [GOLD_W:0] mask;
        logic [GOLD_W:0] bx;
        one  = (GOLD_W+1)'(1);
        mask = (one << w) - one;
        bx   = {1'b0, b} ^ (op ? mask : '0);
        return {1'b0, a} + bx + {{GOLD_W{1'b0}}, op};
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational expected-result generator for a WIDTH-bit add/subtract datapath.
module alu_golden_model
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] exp_s,
    output logic             exp_cout
);

    logic [WIDTH:0] r;

    assign r = (WIDTH+1)'(golden(GOLD_W'(a), GOLD_W'(b), op, WIDTH));
    assign {exp_cout, exp_s} = r;

endmodule

// File: rtl/alu_response_checker.sv
// Checks observed adder/subtractor results against the golden model, counting
// vectors and mismatches and capturing the first failing vector of each run.
module alu_response_checker
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_index,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_op,
    output logic             fail_cout,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] exp_s;
    logic             exp_cout;
    logic             accept;
    logic             start_run;
    logic             mismatch;

    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .a        (in_a),
        .b        (in_b),
        .op       (in_op),
        .exp_s    (exp_s),
        .exp_cout (exp_cout)
    );

    // Handshake: a vector transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready depends only on state, never on in_valid.
    assign in_ready  = (state == RUN);
    assign accept    = in_valid & in_ready;
    assign start_run = start & (state != RUN);
    assign mismatch  = (in_s != exp_s) | (in_cout != exp_cout);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && in_last) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start_run) begin
            busy       <= start_run;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_index <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_s     <= '0;
            fail_op    <= 1'b0;
            fail_cout  <= 1'b0;
        end else if (accept) begin
            if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_ONE;
            if (mismatch && err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
            if (mismatch && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_index <= vec_count;
                fail_a     <= in_a;
                fail_b     <= in_b;
                fail_s     <= in_s;
                fail_op    <= in_op;
                fail_cout  <= in_cout;
            end
            // pass folds in the final vector's own result, since err_count lags by one edge.
            if (in_last) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= !mismatch && (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// Randomized and directed bench for alu_response_checker with a behavioural model.
module tb_alu_response_checker;
    import alu_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_op = 1'b0;
    logic [3:0] in_s = '0;
    logic       in_cout = 1'b0;
    logic       in_last = 1'b0;

    logic       in_ready, busy, done, pass, fail_valid, fail_op, fail_cout;
    logic [7:0] vec_count, err_count, fail_index;
    logic [3:0] fail_a, fail_b, fail_s;
    state_t     dbg_state;

    logic       in_ready2, busy2, done2, pass2, fail_valid2, fail_op2, fail_cout2;
    logic [1:0] vec_count2, err_count2, fail_index2;
    logic [3:0] fail_a2, fail_b2, fail_s2;
    state_t     dbg_state2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] exp_q[$];
    bit         m_run, m_done, m_fv, m_fop, m_fc;
    int         m_vec, m_err, m_fidx;
    logic [3:0] m_fa, m_fb, m_fs;

    alu_response_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_s(in_s), .in_cout(in_cout),
        .in_last(in_last), .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
        .err_count(err_count), .fail_valid(fail_valid), .fail_index(fail_index),
        .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s), .fail_op(fail_op),
        .fail_cout(fail_cout), .dbg_state(dbg_state)
    );

    alu_response_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_s(in_s), .in_cout(in_cout),
        .in_last(in_last), .busy(busy2), .done(done2), .pass(pass2), .vec_count(vec_count2),
        .err_count(err_count2), .fail_valid(fail_valid2), .fail_index(fail_index2),
        .fail_a(fail_a2), .fail_b(fail_b2), .fail_s(fail_s2), .fail_op(fail_op2),
        .fail_cout(fail_cout2), .dbg_state(dbg_state2)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; subtract carry means "no borrow".
    function automatic logic [4:0] ref_result(int a, int b, bit op);
        int t;
        logic [4:0] r;
        t = op ? a - b : a + b;
        r[3:0] = 4'(t & 15);
        r[4]   = op ? (a >= b) : (t > 15);
        return r;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_fv = 0; m_fidx = 0;
        m_fa = '0; m_fb = '0; m_fs = '0; m_fop = 0; m_fc = 0;
    endtask

    // Driver: one clock of stimulus, model advanced on the same edge.
    task automatic cycle(bit st, bit v, logic [3:0] a, logic [3:0] b, bit op,
                         logic [3:0] s, bit c, bit last);
        logic [4:0] e;
        start = st; in_valid = v; in_a = a; in_b = b; in_op = op;
        in_s = s; in_cout = c; in_last = last;
        n_cmp++;
        if (in_ready !== m_run) begin
            n_bad++;
            $display("FAIL in_ready: got %0b want %0b", in_ready, m_run);
        end
        @(posedge clk);
        if (m_run) begin
            if (v) begin
                exp_q.push_back(ref_result(a, b, op));
                e = exp_q.pop_front();
                if ({c, s} !== e) begin
                    if (!m_fv) begin
                        m_fv = 1; m_fidx = m_vec; m_fa = a; m_fb = b; m_fs = s; m_fop = op; m_fc = c;
                    end
                    m_err++;
                end
                m_vec++;
                if (last) begin m_run = 0; m_done = 1; end
            end
        end else if (st) begin
            model_clear();
            m_run = 1; m_done = 0;
        end
        #1;
        start = 0; in_valid = 0; in_last = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        n_cmp++;
        if ({busy, done, pass, vec_count, err_count, fail_valid, fail_index} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want all 0",
                     {busy, done, pass, vec_count, err_count, fail_valid, fail_index});
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        cycle(0, 1, 4'd1, 4'd2, 0, 4'd3, 0, 0);
        cycle(0, 1, 4'd1, 4'd2, 0, 4'd3, 0, 1);
        n_cmp++;
        if (vec_count !== 8'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore: vec %0d busy %0b want 0 0", vec_count, busy);
        end
    endtask

    task automatic test_add();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || vec_count !== 8'd0) begin
            n_bad++;
            $display("FAIL start_timing: busy %0b ready %0b vec %0d want 1 1 0", busy, in_ready, vec_count);
        end
        cycle(0, 1, 4'b0100, 4'b0011, 0, 4'b0111, 0, 0);
        cycle(0, 1, 4'b1101, 4'b1010, 0, 4'b0111, 1, 0);
        cycle(0, 1, 4'b1110, 4'b1001, 0, 4'b0111, 1, 0);
        cycle(0, 1, 4'b1111, 4'b1010, 0, 4'b1001, 1, 1);
        n_cmp++;
        if ({vec_count, err_count} !== {8'd4, 8'd0}) begin
            n_bad++; $display("FAIL add_counts: vec %0d err %0d want 4 0", vec_count, err_count);
        end
        n_cmp++;
        if ({done, pass, busy, fail_valid} !== 4'b1100) begin
            n_bad++; $display("FAIL add_status: got %b want 1100", {done, pass, busy, fail_valid});
        end
    endtask

    task automatic test_sub();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'b0100, 4'b0011, 1, 4'b0001, 1, 0);
        cycle(0, 1, 4'b0011, 4'b0100, 1, 4'b1111, 0, 1);
        n_cmp++;
        if ({done, pass, err_count} !== {2'b11, 8'd0}) begin
            n_bad++; $display("FAIL sub_pass: done %0b pass %0b err %0d want 1 1 0", done, pass, err_count);
        end
    endtask

    task automatic test_mismatch();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'b0100, 4'b0011, 0, 4'b0111, 0, 0);
        cycle(0, 1, 4'b1101, 4'b1010, 0, 4'b0111, 0, 0);
        cycle(0, 1, 4'b0001, 4'b0001, 0, 4'b0011, 0, 1);
        n_cmp++;
        if ({err_count, fail_index} !== {8'd2, 8'd1}) begin
            n_bad++; $display("FAIL mm_counts: err %0d idx %0d want 2 1", err_count, fail_index);
        end
        n_cmp++;
        if ({fail_valid, fail_a, fail_b, fail_s, fail_op, fail_cout} !== {1'b1, 4'b1101, 4'b1010, 4'b0111, 2'b00}) begin
            n_bad++;
            $display("FAIL mm_capture: v %0b a %b b %b s %b op %0b c %0b want 1 1101 1010 0111 0 0",
                     fail_valid, fail_a, fail_b, fail_s, fail_op, fail_cout);
        end
        n_cmp++;
        if ({done, pass} !== 2'b10) begin
            n_bad++; $display("FAIL mm_pass: done %0b pass %0b want 1 0", done, pass);
        end
    endtask

    task automatic test_ignore();
        repeat (3) cycle(0, 1, 4'd2, 4'd2, 0, 4'd4, 0, 0);
        n_cmp++;
        if ({vec_count, err_count, done} !== {8'd3, 8'd2, 1'b1}) begin
            n_bad++; $display("FAIL done_ignore: vec %0d err %0d done %0b want 3 2 1", vec_count, err_count, done);
        end
        cycle(1, 1, 4'd2, 4'd2, 0, 4'd4, 0, 0);
        cycle(0, 1, 4'd2, 4'd2, 0, 4'd4, 0, 0);
        cycle(1, 1, 4'd3, 4'd2, 0, 4'd5, 0, 0);
        n_cmp++;
        if ({vec_count, busy, done} !== {8'd2, 2'b10}) begin
            n_bad++; $display("FAIL start_in_run: vec %0d busy %0b done %0b want 2 1 0", vec_count, busy, done);
        end
        cycle(0, 1, 4'd3, 4'd3, 0, 4'd6, 0, 1);
        n_cmp++;
        if ({vec_count, pass} !== {8'd3, 1'b1}) begin
            n_bad++; $display("FAIL ignore_end: vec %0d pass %0b want 3 1", vec_count, pass);
        end
    endtask

    task automatic test_saturate();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 4'd0, 4'd0, 0, 4'd1, 0, i == 5);
        n_cmp++;
        if ({vec_count2, err_count2, fail_index2, fail_valid2, pass2, done2} !== {2'd3, 2'd3, 2'd0, 3'b101}) begin
            n_bad++;
            $display("FAIL sat_narrow: vec %0d err %0d idx %0d v %0b pass %0b done %0b want 3 3 0 1 0 1",
                     vec_count2, err_count2, fail_index2, fail_valid2, pass2, done2);
        end
        n_cmp++;
        if ({vec_count, err_count} !== {8'd6, 8'd6}) begin
            n_bad++; $display("FAIL sat_wide: vec %0d err %0d want 6 6", vec_count, err_count);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'd5, 4'd1, 1, 4'd4, 1, 0);
        cycle(0, 1, 4'd5, 4'd1, 1, 4'd0, 1, 0);
        rst_n = 0;
        @(posedge clk);
        m_run = 0; m_done = 0; model_clear();
        #1;
        n_cmp++;
        if ({in_ready, busy, done, pass, vec_count, err_count, fail_valid, fail_index,
             fail_a, fail_b, fail_s, fail_op, fail_cout} !== '0 || dbg_state !== IDLE) begin
            n_bad++; $display("FAIL mid_reset: outputs not cleared, vec %0d err %0d busy %0b",
                              vec_count, err_count, busy);
        end
        rst_n = 1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'd7, 4'd8, 0, 4'd15, 0, 1);
        n_cmp++;
        if ({vec_count, done, pass} !== {8'd1, 2'b11}) begin
            n_bad++; $display("FAIL after_reset: vec %0d done %0b pass %0b want 1 1 1", vec_count, done, pass);
        end
    endtask

    task automatic test_random();
        int len;
        logic [3:0] a, b;
        bit op;
        logic [4:0] e;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 20);
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, 0, 0, 0, 0);
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                op = 1'($urandom_range(0, 1));
                e = ref_result(a, b, op);
                if ($urandom_range(0, 3) == 0) e = e ^ 5'($urandom_range(1, 31));
                cycle(0, 1, a, b, op, e[3:0], e[4], i == len - 1);
                n_cmp++;
                if (vec_count !== 8'(sat(m_vec, 255)) || err_count !== 8'(sat(m_err, 255))) begin
                    n_bad++; $display("FAIL rnd_counts: vec %0d err %0d want %0d %0d",
                                      vec_count, err_count, m_vec, m_err);
                end
            end
            n_cmp++;
            if ({done, busy, pass} !== {m_done, m_run, m_done && m_err == 0}) begin
                n_bad++; $display("FAIL rnd_status: done %0b busy %0b pass %0b want %0b %0b %0b",
                                  done, busy, pass, m_done, m_run, m_done && m_err == 0);
            end
            n_cmp++;
            if ({fail_valid, fail_index, fail_a, fail_b, fail_s, fail_op, fail_cout} !==
                {m_fv, 8'(m_fidx), m_fa, m_fb, m_fs, m_fop, m_fc}) begin
                n_bad++; $display("FAIL rnd_capture: v %0b idx %0d a %h b %h s %h want %0b %0d %h %h %h",
                                  fail_valid, fail_index, fail_a, fail_b, fail_s, m_fv, m_fidx, m_fa, m_fb, m_fs);
            end
            n_cmp++;
            if ({vec_count2, err_count2} !== {2'(sat(m_vec, 3)), 2'(sat(m_err, 3))}) begin
                n_bad++; $display("FAIL rnd_narrow: vec %0d err %0d want %0d %0d",
                                  vec_count2, err_count2, sat(m_vec, 3), sat(m_err, 3));
            end
        end
    endtask

    initial begin
        m_run = 0; m_done = 0; model_clear();
        test_reset();
        test_add();
        test_sub();
        test_mismatch();
        test_ignore();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
